// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: stage 1 captures the operation,
// stage 2 registers the result, its flags and counts completed handshakes.
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_par,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic               s1_v;
  op_e                s1_op;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;

  logic               s2_v;
  logic [WIDTH-1:0]   s2_y;
  logic               s2_zero;
  logic               s2_ones;
  logic               s2_par;
  logic [COUNT_W-1:0] count_q;

  logic               s1_load;
  logic               s2_load;
  logic               out_fire;
  logic [WIDTH-1:0]   y_next;

  // in_ready looks only at registered state and out_ready, never at in_valid.
  assign in_ready = !s1_v || !s2_v || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_v && (!s2_v || out_ready);
  assign out_fire = s2_v && out_ready;

  always_comb begin
    y_next = '0;
    unique case (s1_op)
      OP_NOT:  y_next = ~s1_a;
      OP_AND:  y_next = s1_a & s1_b;
      OP_OR:   y_next = s1_a | s1_b;
      OP_NOR:  y_next = ~(s1_a | s1_b);
      OP_NAND: y_next = ~(s1_a & s1_b);
      OP_XOR:  y_next = s1_a ^ s1_b;
      OP_XNOR: y_next = ~(s1_a ^ s1_b);
      OP_PASS: y_next = s1_a;
      default: y_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_op <= OP_NOT;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (s1_load) begin
      s1_v  <= 1'b1;
      s1_op <= op_e'(in_op);
      s1_a  <= in_a;
      s1_b  <= in_b;
    end else if (s2_load) begin
      s1_v  <= 1'b0;
    end
  end

  // Flags come from the same y being registered, so they always match out_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_y    <= '0;
      s2_zero <= 1'b1;
      s2_ones <= 1'b0;
      s2_par  <= 1'b0;
    end else if (s2_load) begin
      s2_v    <= 1'b1;
      s2_y    <= y_next;
      s2_zero <= (y_next == '0);
      s2_ones <= &y_next;
      s2_par  <= ^y_next;
    end else if (out_fire) begin
      s2_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (out_fire) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign out_valid = s2_v;
  assign out_y     = s2_y;
  assign out_zero  = s2_zero;
  assign out_ones  = s2_ones;
  assign out_par   = s2_par;
  assign op_count  = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed sequences plus randomized
// traffic scored against a queue-based model of the two-entry pipeline.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic        out_zero;
  logic        out_ones;
  logic        out_par;
  logic [15:0] op_count;

  logic        w_in_valid;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [7:0]  w_out_y;
  logic        w_out_zero;
  logic        w_out_ones;
  logic        w_out_par;
  logic [3:0]  w_op_count;

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_ones(out_ones), .out_par(out_par), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(3'd5), .in_a(8'h3C), .in_b(8'hC3),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_y(w_out_y),
    .out_zero(w_out_zero), .out_ones(w_out_ones), .out_par(w_out_par), .op_count(w_op_count)
  );

  typedef struct {
    logic [7:0] y;
    int         acc;
  } item_t;

  item_t      sb[$];
  logic [7:0] seen_y[$];
  logic [2:0] seen_flags[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hs = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_gate(input int op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] and_v, or_v, xor_v;
    and_v = a & b;
    or_v  = a | b;
    xor_v = a ^ b;
    case (op)
      0: return ~a;
      1: return and_v;
      2: return or_v;
      3: return ~or_v;
      4: return ~and_v;
      5: return xor_v;
      6: return ~xor_v;
      default: return a;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [7:0] y);
    int ones;
    ones = $countones(y);
    return {ones == 0, ones == 8, (ones % 2) == 1};
  endfunction

  // One clock of traffic; the pipeline holds at most two items, and the oldest
  // is visible once it has been inside for more than one edge or has company.
  task automatic applyStimulus(input logic iv, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic ordy, output logic accepted);
    logic exp_ov;
    @(negedge clk);
    in_valid  = iv;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    exp_ov = (sb.size() >= 2) || (sb.size() == 1 && sb[0].acc < cyc - 1);
    checkOutput("in_ready", in_ready, (sb.size() < 2) || ordy);
    checkOutput("out_valid", out_valid, exp_ov);
    if (out_valid && exp_ov) begin
      checkOutput("out_y", out_y, sb[0].y);
      checkOutput("flags", {out_zero, out_ones, out_par}, ref_flags(sb[0].y));
    end
    accepted = iv && in_ready;
    if (out_valid && ordy && sb.size() > 0) begin
      seen_y.push_back(out_y);
      seen_flags.push_back({out_zero, out_ones, out_par});
      void'(sb.pop_front());
      hs++;
    end
    if (accepted) sb.push_back('{ref_gate(int'(op), a, b), cyc});
    cyc++;
    @(posedge clk);
    #1;
    checkOutput("op_count", op_count, hs[15:0]);
  endtask

  logic [7:0] sweep_exp [8];
  logic       acc;
  logic       pv;
  logic [2:0] r_op;
  logic [7:0] r_a, r_b;
  logic [2:0] bp_op [3];
  logic [7:0] bp_a [3];
  logic [7:0] bp_b [3];
  int         sent;
  int         wsent;
  int         whs;
  logic       wfire_in, wfire_out;

  initial begin
    sweep_exp = '{8'h5A, 8'h24, 8'hBD, 8'h42, 8'hDB, 8'h99, 8'h66, 8'hA5};
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
    out_ready = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_y", out_y, 0);
    checkOutput("rst_flags", {out_zero, out_ones, out_par}, 3'b100);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] opcode sweep");
    seen_y.delete();
    for (int op = 0; op < 8; op++) applyStimulus(1'b1, 3'(op), 8'hA5, 8'h3C, 1'b1, acc);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
    checkOutput("sweep_n", seen_y.size(), 8);
    for (int i = 0; i < 8 && i < seen_y.size(); i++) checkOutput("sweep_y", seen_y[i], sweep_exp[i]);
    checkOutput("sweep_count", op_count, 8);

    $display("[TB] flags");
    seen_y.delete(); seen_flags.delete();
    applyStimulus(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b1, acc);
    applyStimulus(1'b1, 3'd3, 8'h00, 8'h00, 1'b1, acc);
    applyStimulus(1'b1, 3'd7, 8'h01, 8'hFF, 1'b1, acc);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
    checkOutput("flags_n", seen_flags.size(), 3);
    if (seen_flags.size() == 3) begin
      checkOutput("and_y", seen_y[0], 8'h00);
      checkOutput("and_flags", seen_flags[0], 3'b100);
      checkOutput("nor_y", seen_y[1], 8'hFF);
      checkOutput("nor_flags", seen_flags[1], 3'b010);
      checkOutput("pass_flags", seen_flags[2], 3'b001);
    end

    $display("[TB] backpressure");
    seen_y.delete();
    for (int i = 0; i < 3; i++) begin
      bp_op[i] = 3'(i * 2 + 1); bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom);
    end
    applyStimulus(1'b1, bp_op[0], bp_a[0], bp_b[0], 1'b0, acc);
    checkOutput("bp_acc0", acc, 1);
    applyStimulus(1'b1, bp_op[1], bp_a[1], bp_b[1], 1'b0, acc);
    checkOutput("bp_acc1", acc, 1);
    applyStimulus(1'b1, bp_op[2], bp_a[2], bp_b[2], 1'b0, acc);
    checkOutput("bp_acc2", acc, 0);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_hold", out_y, ref_gate(int'(bp_op[0]), bp_a[0], bp_b[0]));
    applyStimulus(1'b1, bp_op[2], bp_a[2], bp_b[2], 1'b1, acc);
    checkOutput("bp_acc3", acc, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
    checkOutput("bp_n", seen_y.size(), 3);
    for (int i = 0; i < 3 && i < seen_y.size(); i++)
      checkOutput("bp_order", seen_y[i], ref_gate(int'(bp_op[i]), bp_a[i], bp_b[i]));

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 3'd2, 8'h12, 8'h34, 1'b0, acc);
    applyStimulus(1'b1, 3'd5, 8'h56, 8'h78, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_y", out_y, 0);
    checkOutput("mid_rst_op_count", op_count, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    hs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);

    $display("[TB] random traffic");
    sent = 0; pv = 1'b0; r_op = 3'd0; r_a = 8'h00; r_b = 8'h00;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1; r_op = 3'($urandom); r_a = 8'($urandom); r_b = 8'($urandom);
      end
      applyStimulus(pv, r_op, r_a, r_b, $urandom_range(0, 2) != 0, acc);
      if (acc) begin
        pv = 1'b0;
        sent++;
      end
    end
    checkOutput("rand_sent", sent, 1000);
    for (int c = 0; c < 20 && sb.size() > 0; c++) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
    checkOutput("drain_empty", sb.size(), 0);

    $display("[TB] counter wrap");
    wsent = 0; whs = 0;
    for (int c = 0; c < 60 && whs < 17; c++) begin
      @(negedge clk);
      w_in_valid = (wsent < 17);
      w_out_ready = 1'b1;
      #1;
      wfire_in  = w_in_valid && w_in_ready;
      wfire_out = w_out_valid && w_out_ready;
      @(posedge clk);
      #1;
      if (wfire_in) wsent++;
      if (wfire_out) begin
        whs++;
        if (whs == 15) checkOutput("wrap_15", w_op_count, 4'd15);
        if (whs == 16) checkOutput("wrap_16", w_op_count, 4'd0);
        if (whs == 17) checkOutput("wrap_17", w_op_count, 4'd1);
      end
    end
    checkOutput("wrap_hs", whs, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
